// File: rtl/pico_mem_responder.sv
// pico_mem_responder: memory-side responder for the picorv32 native bus.
// Serves fetches/loads/stores from an internal word RAM after a fixed number
// of wait states, exposes a write-only console byte sink, a sticky
// out-of-range error flag and saturating access/fetch counters.
// Optional macro PICO_MEM_LFSR_WAIT_EN: wait count per request comes from a
// 16-bit Fibonacci LFSR (taps 16,14,13,11) instead of WAIT_CYCLES.
module pico_mem_responder #(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        err,
    output logic [31:0] access_cnt,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;       // word address; byte offset is ignored
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic        err_q, err_d;
    logic [31:0] access_cnt_q, access_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] ram_q [MEM_WORDS];    // not cleared by reset

    logic          accept;
    logic [3:0]    wait_load;
    logic          resp;
    logic          is_console;
    logic          in_ram;
    logic          is_write;
    logic          ram_we;
    logic [AW-1:0] ram_idx;

    assign accept = (state_q == ST_IDLE) && mem_valid;

`ifdef PICO_MEM_LFSR_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic        unused_cfg;

    assign unused_cfg = ^WAIT_CYCLES;
    assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign wait_load  = {2'b00, lfsr_step[1:0]};

    // LFSR advances once per accepted request
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) lfsr_d = lfsr_step;
    end

    // LFSR register, reloaded with the seed on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^LFSR_SEED;
    assign wait_load  = 4'(WAIT_CYCLES);
`endif

    logic unused_addr;
    assign unused_addr = ^mem_addr[1:0];

    // Decode of the latched request; console wins over an overlapping RAM range
    assign resp       = (state_q == ST_RESP);
    assign is_console = (addr_q == CONSOLE_ADDR[31:2]);
    assign in_ram     = !is_console && ({2'b00, addr_q} < 32'(MEM_WORDS));
    assign is_write   = |wstrb_q;
    assign ram_we     = resp && in_ram && is_write;
    assign ram_idx    = addr_q[AW-1:0];

    // Next-state, request latch, error flag and counters
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        err_d        = err_q;
        access_cnt_d = access_cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = wait_load;
                    state_d = (wait_load == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leaving on count 1 gives ready WAIT_CYCLES+1 edges after acceptance
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!is_console && !in_ram) err_d = 1'b1;
                if (access_cnt_q != 32'hFFFF_FFFF) access_cnt_d = access_cnt_q + 32'd1;
                if (instr_q && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            err_q        <= 1'b0;
            access_cnt_q <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            instr_q      <= instr_d;
            err_q        <= err_d;
            access_cnt_q <= access_cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Byte-lane RAM write on the RESP edge; a reset drops any pending write
    always_ff @(posedge clk) begin
        if (resetn && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) ram_q[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // Response outputs are only non-zero during the single RESP cycle
    always_comb begin
        mem_ready     = resp;
        mem_rdata     = '0;
        console_valid = 1'b0;
        console_data  = '0;
        if (resp) begin
            if (is_console && is_write) begin
                console_valid = 1'b1;
                console_data  = wdata_q[7:0];
            end else if (in_ram && !is_write) begin
                mem_rdata = ram_q[ram_idx];
            end
        end
    end

    assign err        = err_q;
    assign access_cnt = access_cnt_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_pico_mem_responder.sv
// Bench for pico_mem_responder: randomized bus traffic against a
// transaction-level reference model (word map, counters, error flag, latency).
module tb_pico_mem_responder;
    localparam int unsigned MEM_WORDS    = 4096;
    localparam int unsigned WAIT_CYCLES  = 2;
    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        err;
    logic [31:0] access_cnt;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] ref_mem [int];
    logic [31:0] ref_acc;
    logic [31:0] ref_fetch;
    logic        ref_err;
    logic [15:0] ref_lfsr;

    pico_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES),
        .CONSOLE_ADDR(CONSOLE_ADDR), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .console_valid(console_valid),
        .console_data(console_data), .err(err), .access_cnt(access_cnt), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic ref_reset();
        ref_acc = '0; ref_fetch = '0; ref_err = 1'b0; ref_lfsr = LFSR_SEED;
    endtask

    // expected edges from acceptance until ready is seen
    task automatic next_lat(output int lat);
`ifdef PICO_MEM_LFSR_WAIT_EN
        ref_lfsr = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        lat = int'(ref_lfsr[1:0]) + 1;
`else
        lat = WAIT_CYCLES + 1;
`endif
    endtask

    // one whole transaction as seen from the bus
    task automatic ref_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input bit ins, output logic [31:0] rd, output bit cv,
                              output logic [7:0] cd, output int lat);
        int unsigned widx;
        logic [31:0] w;
        widx = int'(a >> 2);
        rd = '0; cv = 1'b0; cd = '0;
        next_lat(lat);
        if ((a >> 2) == (CONSOLE_ADDR >> 2)) begin
            if (s != 4'b0) begin cv = 1'b1; cd = d[7:0]; end
        end else if (widx < MEM_WORDS) begin
            w = ref_mem.exists(int'(widx)) ? ref_mem[int'(widx)] : 32'hxxxx_xxxx;
            if (s == 4'b0) rd = w;
            else begin
                for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
                ref_mem[int'(widx)] = w;
            end
        end else begin
            ref_err = 1'b1;
        end
        if (ref_acc != 32'hFFFF_FFFF) ref_acc = ref_acc + 1;
        if (ins && ref_fetch != 32'hFFFF_FFFF) ref_fetch = ref_fetch + 1;
    endtask

    // drive one request and hold it until ready (bounded)
    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit ins, output logic [31:0] rd, output int lat,
                        output bit cv, output logic [7:0] cd);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
        lat = 0; rd = '0; cv = 1'b0; cd = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 40);
        if (mem_ready) begin rd = mem_rdata; cv = console_valid; cd = console_data; end
        mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ref_reset();
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", mem_ready); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
        checks++; if (console_valid !== 1'b0) begin errors++; $display("FAIL rst_cvalid got %b want 0", console_valid); end
        checks++; if (console_data !== 8'h0) begin errors++; $display("FAIL rst_cdata got %h want 0", console_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (access_cnt !== 32'h0) begin errors++; $display("FAIL rst_acc got %0d want 0", access_cnt); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_fetch got %0d want 0", fetch_cnt); end
        resetn = 1'b1;
        ref_reset();
    endtask

    task automatic test_read_latency();
        logic [31:0] rd, erd; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        xact(32'h10, 32'h1234_5678, 4'hF, 1'b0, rd, lat, cv, cd);
        ref_access(32'h10, 32'h1234_5678, 4'hF, 1'b0, erd, ecv, ecd, elat);
        apply_reset();   // RAM contents survive this
        xact(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h10, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (lat !== elat) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, elat); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL rd_data got %h want %h", rd, erd); end
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse got %b want 0", mem_ready); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rd_rdata_idle got %h want 0", mem_rdata); end
        checks++; if (access_cnt !== ref_acc) begin errors++; $display("FAIL rd_acc got %0d want %0d", access_cnt, ref_acc); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd, erd; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        xact(32'h20, 32'hAABB_CCDD, 4'hF, 1'b0, rd, lat, cv, cd);
        ref_access(32'h20, 32'hAABB_CCDD, 4'hF, 1'b0, erd, ecv, ecd, elat);
        xact(32'h20, 32'h1122_3344, 4'b0101, 1'b0, rd, lat, cv, cd);
        ref_access(32'h20, 32'h1122_3344, 4'b0101, 1'b0, erd, ecv, ecd, elat);
        checks++; if (lat !== elat) begin errors++; $display("FAIL wstrb_latency got %0d want %0d", lat, elat); end
        xact(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h20, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL wstrb_merge got %h want %h", rd, erd); end
    endtask

    task automatic test_console();
        logic [31:0] rd, erd; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        xact(32'h1000_0000, 32'h0000_0041, 4'h1, 1'b0, rd, lat, cv, cd);
        ref_access(32'h1000_0000, 32'h0000_0041, 4'h1, 1'b0, erd, ecv, ecd, elat);
        checks++; if (cv !== ecv) begin errors++; $display("FAIL con_valid got %b want %b", cv, ecv); end
        checks++; if (cd !== ecd) begin errors++; $display("FAIL con_data got %h want %h", cd, ecd); end
        @(negedge clk);
        checks++; if (console_valid !== 1'b0) begin errors++; $display("FAIL con_pulse got %b want 0", console_valid); end
        checks++; if (err !== ref_err) begin errors++; $display("FAIL con_err got %b want %b", err, ref_err); end
        xact(32'h1000_0002, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h1000_0002, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (rd !== erd || cv !== ecv) begin errors++; $display("FAIL con_read got %h/%b want %h/%b", rd, cv, erd, ecv); end
        xact(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h20, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL con_ram_kept got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d; logic [3:0] s; bit ins;
        int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            xact(32'h400 + 32'(4*k), d, 4'hF, 1'b0, rd, lat, cv, cd);
            ref_access(32'h400 + 32'(4*k), d, 4'hF, 1'b0, erd, ecv, ecd, elat);
        end
        for (int n = 0; n < 40; n++) begin
            a   = 32'h400 + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
            d   = $urandom;
            s   = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
            ins = 1'($urandom_range(1));
            xact(a, d, s, ins, rd, lat, cv, cd);
            ref_access(a, d, s, ins, erd, ecv, ecd, elat);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, elat); end
            if (s == 4'h0) begin
                checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", n, a, rd, erd); end
            end
        end
        @(negedge clk);
        checks++; if (access_cnt !== ref_acc) begin errors++; $display("FAIL rnd_acc got %0d want %0d", access_cnt, ref_acc); end
        checks++; if (fetch_cnt !== ref_fetch) begin errors++; $display("FAIL rnd_fetch got %0d want %0d", fetch_cnt, ref_fetch); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        xact(32'h0001_0000, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h0001_0000, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (lat !== elat) begin errors++; $display("FAIL oor_latency got %0d want %0d", lat, elat); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL oor_rdata got %h want %h", rd, erd); end
        @(negedge clk);
        checks++; if (err !== ref_err) begin errors++; $display("FAIL oor_err got %b want %b", err, ref_err); end
        xact(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, lat, cv, cd);
        ref_access(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b0, erd, ecv, ecd, elat);
        xact(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h20, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL oor_legal_read got %h want %h", rd, erd); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd;
        xact(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat, cv, cd);
        ref_access(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, erd, ecv, ecd, elat);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'hF;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", mem_ready); end
        checks++; if (access_cnt !== 32'h0) begin errors++; $display("FAIL mid_acc got %0d want 0", access_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        mem_valid = 1'b0; mem_wstrb = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ref_reset();
        xact(32'h40, 32'h0, 4'h0, 1'b0, rd, lat, cv, cd);
        ref_access(32'h40, 32'h0, 4'h0, 1'b0, erd, ecv, ecd, elat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL mid_old_data got %h want %h", rd, erd); end
        checks++; if (lat !== elat) begin errors++; $display("FAIL mid_latency got %0d want %0d", lat, elat); end
    endtask

    task automatic test_counts();
        logic [31:0] rd, erd, a; int lat, elat; bit cv, ecv; logic [7:0] cd, ecd; bit ins;
        apply_reset();
        for (int n = 0; n < 15; n++) begin
            ins = (n < 10);
            a   = 32'h400 + 32'(4 * $urandom_range(15));
            xact(a, 32'h0, 4'h0, ins, rd, lat, cv, cd);
            ref_access(a, 32'h0, 4'h0, ins, erd, ecv, ecd, elat);
            checks++; if (lat !== elat) begin errors++; $display("FAIL cnt_latency[%0d] got %0d want %0d", n, lat, elat); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL cnt_rdata[%0d] got %h want %h", n, rd, erd); end
        end
        @(negedge clk);
        checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL cnt_fetch got %0d want 10", fetch_cnt); end
        checks++; if (access_cnt !== 32'd15) begin errors++; $display("FAIL cnt_access got %0d want 15", access_cnt); end
    endtask

    initial begin
        ref_reset();
        test_reset();
        test_read_latency();
        test_byte_strobe();
        test_console();
        test_random();
        test_out_of_range();
        test_reset_mid();
        test_counts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
